// File: rtl/ram_pkg.sv
// Shared types and sizing for the RAM write buffer.
// Entry layout is common to the buffer storage and the match search.
package ram_pkg;

  localparam int RAM_DATA_WIDTH = 16;
  localparam int RAM_WORDS      = 1024;
  localparam int ADDR_BITS      = $clog2(RAM_WORDS);
  localparam int WB_DEPTH       = 4;

  typedef struct packed {
    logic [ADDR_BITS-1:0]      addr;
    logic [RAM_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-match search over the valid window of the write buffer.
// Later (younger) matches override earlier ones in the scan.
module wb_match
  import ram_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int IW    = $clog2(DEPTH),
  parameter int PW    = IW + 1
) (
  input  wb_entry_t            entries [DEPTH],
  input  logic [PW-1:0]        rd_ptr,
  input  logic [PW-1:0]        wr_ptr,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 hit,
  output logic [IW-1:0]        idx
);

  logic [PW-1:0] cnt;
  logic [IW-1:0] slot;

  assign cnt = wr_ptr - rd_ptr;

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr[IW-1:0] + IW'(k);
      if (PW'(k) < cnt && entries[slot].addr == addr) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/ram_write_buffer.sv
// Posted-write FIFO between the cache memory port and the data RAM.
// Read misses bypass pending drains; read hits forward buffered data.
module ram_write_buffer
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH         = RAM_DATA_WIDTH,
  parameter int RAM_REGISTER_COUNT = RAM_WORDS,
  parameter int DEPTH              = WB_DEPTH,
  parameter int AW                 = $clog2(RAM_REGISTER_COUNT),
  parameter int IW                 = $clog2(DEPTH),
  parameter int PW                 = IW + 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [DATA_WIDTH-1:0] up_out_m,
  input  logic                  up_write_m,
  input  logic                  up_read_m,
  input  logic [AW-1:0]         up_data_addr,
  output logic [DATA_WIDTH-1:0] up_in_m,
  output logic                  up_stall,
  input  logic [DATA_WIDTH-1:0] mem_in_m,
  output logic [DATA_WIDTH-1:0] mem_out_m,
  output logic                  mem_write_m,
  output logic                  mem_read_m,
  output logic [AW-1:0]         mem_data_addr,
  input  logic                  mem_ready,
  output logic [PW-1:0]         buf_count
);

  wb_entry_t     buf_q [DEPTH];
  wb_entry_t     head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          rd_miss;
  logic          drain;
  logic          push;
  logic          pop;

  wb_match #(.DEPTH(DEPTH)) u_match (
    .entries (buf_q),
    .rd_ptr  (rd_ptr),
    .wr_ptr  (wr_ptr),
    .addr    (up_data_addr),
    .hit     (hit),
    .idx     (hit_idx)
  );

  assign buf_count = wr_ptr - rd_ptr;
  assign empty     = wr_ptr == rd_ptr;
  assign full      = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0])
                  && (wr_ptr[IW] != rd_ptr[IW]);
  assign head      = buf_q[rd_ptr[IW-1:0]];

  assign rd_miss  = up_read_m && !hit;
  assign drain    = !empty && !rd_miss;
  // Full stalls even if a pop lands this cycle: keeps mem_ready off the push path.
  assign up_stall = (up_write_m && full) || (rd_miss && !mem_ready);
  assign push     = up_write_m && !up_stall;
  assign pop      = drain && mem_ready;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr[IW-1:0]] <= '{addr: up_data_addr, data: up_out_m};
    end
  end

  always_comb begin
    mem_write_m   = 1'b0;
    mem_read_m    = 1'b0;
    mem_data_addr = '0;
    mem_out_m     = '0;
    up_in_m       = '0;
    unique case (1'b1)
      rd_miss: begin
        mem_read_m    = 1'b1;
        mem_data_addr = up_data_addr;
        up_in_m       = mem_in_m;
      end
      drain: begin
        mem_write_m   = 1'b1;
        mem_data_addr = head.addr;
        mem_out_m     = head.data;
      end
      default: ;
    endcase
    if (up_read_m && hit) up_in_m = buf_q[hit_idx].data;
  end

endmodule

// File: tb/tb_ram_write_buffer.sv
// Directed bench for ram_write_buffer with a RAM write log.
// Each task drives one scenario and checks inline.
module tb_ram_write_buffer;

  logic        clk = 1'b0;
  logic        resetN;
  logic [15:0] up_out_m;
  logic        up_write_m;
  logic        up_read_m;
  logic [9:0]  up_data_addr;
  logic [15:0] up_in_m;
  logic        up_stall;
  logic [15:0] mem_in_m;
  logic [15:0] mem_out_m;
  logic        mem_write_m;
  logic        mem_read_m;
  logic [9:0]  mem_data_addr;
  logic        mem_ready;
  logic [2:0]  buf_count;

  int cmp_n = 0;
  int err_n = 0;

  logic [9:0]  log_a [256];
  logic [15:0] log_d [256];
  int          log_n = 0;

  ram_write_buffer dut (
    .clk           (clk),
    .resetN        (resetN),
    .up_out_m      (up_out_m),
    .up_write_m    (up_write_m),
    .up_read_m     (up_read_m),
    .up_data_addr  (up_data_addr),
    .up_in_m       (up_in_m),
    .up_stall      (up_stall),
    .mem_in_m      (mem_in_m),
    .mem_out_m     (mem_out_m),
    .mem_write_m   (mem_write_m),
    .mem_read_m    (mem_read_m),
    .mem_data_addr (mem_data_addr),
    .mem_ready     (mem_ready),
    .buf_count     (buf_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_m && mem_ready && log_n < 256) begin
      log_a[log_n] = mem_data_addr;
      log_d[log_n] = mem_out_m;
      log_n++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    up_out_m = '0; up_write_m = 0; up_read_m = 0;
    up_data_addr = '0; mem_in_m = '0; mem_ready = 1'b1;
    #3;
    cmp_n++; if (buf_count !== 3'd0) begin err_n++;
      $display("FAIL rst_count got %0d want 0", buf_count); end
    cmp_n++; if (up_stall !== 1'b0) begin err_n++;
      $display("FAIL rst_stall got %b want 0", up_stall); end
    cmp_n++; if ({mem_write_m, mem_read_m} !== 2'b00) begin err_n++;
      $display("FAIL rst_strobes got %b want 00", {mem_write_m, mem_read_m}); end
    cmp_n++; if ({mem_out_m, mem_data_addr} !== 26'd0) begin err_n++;
      $display("FAIL rst_bus got %h/%h want 0/0", mem_out_m, mem_data_addr); end
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_single;
    up_write_m = 1; up_data_addr = 10'd5; up_out_m = 16'h1234;
    #1;
    cmp_n++; if (up_stall !== 1'b0) begin err_n++;
      $display("FAIL single_stall got %b want 0", up_stall); end
    tick();
    up_write_m = 0;
    #1;
    cmp_n++; if (mem_write_m !== 1'b1) begin err_n++;
      $display("FAIL single_wr got %b want 1", mem_write_m); end
    cmp_n++; if (mem_data_addr !== 10'd5 || mem_out_m !== 16'h1234) begin err_n++;
      $display("FAIL single_bus got %h/%h want 5/1234", mem_data_addr, mem_out_m); end
    cmp_n++; if (buf_count !== 3'd1) begin err_n++;
      $display("FAIL single_cnt1 got %0d want 1", buf_count); end
    tick();
    cmp_n++; if (buf_count !== 3'd0 || mem_write_m !== 1'b0) begin err_n++;
      $display("FAIL single_cnt0 got %0d/%b want 0/0", buf_count, mem_write_m); end
  endtask

  task automatic test_full;
    int base;
    base = log_n;
    mem_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      up_write_m = 1; up_data_addr = 10'(i); up_out_m = 16'(16'hA0 + i);
      #1;
      cmp_n++; if (up_stall !== 1'b0) begin err_n++;
        $display("FAIL full_fill%0d got stall %b want 0", i, up_stall); end
      tick();
    end
    up_data_addr = 10'd6; up_out_m = 16'hA6;
    #1;
    cmp_n++; if (up_stall !== 1'b1 || buf_count !== 3'd4) begin err_n++;
      $display("FAIL full_stall got %b/%0d want 1/4", up_stall, buf_count); end
    mem_ready = 1;
    #1;
    cmp_n++; if (up_stall !== 1'b1) begin err_n++;
      $display("FAIL full_stall_rdy got %b want 1", up_stall); end
    tick();
    mem_ready = 0;
    #1;
    cmp_n++; if (up_stall !== 1'b0 || buf_count !== 3'd3 || mem_data_addr !== 10'd2) begin
      err_n++;
      $display("FAIL full_pop got %b/%0d/%h want 0/3/2", up_stall, buf_count, mem_data_addr); end
    cmp_n++; if (log_n !== base + 1 || log_a[base] !== 10'd1 || log_d[base] !== 16'hA1) begin
      err_n++;
      $display("FAIL full_log1 got n=%0d %h/%h want n=%0d 1/a1",
               log_n - base, log_a[base], log_d[base], 1); end
    tick();
    up_write_m = 0;
    #1;
    cmp_n++; if (buf_count !== 3'd4) begin err_n++;
      $display("FAIL full_push got %0d want 4", buf_count); end
    mem_ready = 1;
    repeat (4) tick();
    cmp_n++; if (buf_count !== 3'd0 || log_n !== base + 5) begin err_n++;
      $display("FAIL full_drain got %0d/%0d want 0/5", buf_count, log_n - base); end
    cmp_n++; if (log_a[base+4] !== 10'd6 || log_d[base+4] !== 16'hA6
                 || log_a[base+3] !== 10'd4) begin err_n++;
      $display("FAIL full_order got %h/%h want 6/a6", log_a[base+4], log_d[base+4]); end
  endtask

  task automatic test_forward;
    mem_ready = 0;
    up_write_m = 1; up_data_addr = 10'd7; up_out_m = 16'h0001;
    tick();
    up_out_m = 16'h0002;
    tick();
    up_write_m = 0; up_read_m = 1; up_data_addr = 10'd7;
    #1;
    cmp_n++; if (up_in_m !== 16'h0002) begin err_n++;
      $display("FAIL fwd_data got %h want 0002", up_in_m); end
    cmp_n++; if (up_stall !== 1'b0 || mem_read_m !== 1'b0) begin err_n++;
      $display("FAIL fwd_ctl got %b/%b want 0/0", up_stall, mem_read_m); end
  endtask

  task automatic test_miss;
    int base;
    up_data_addr = 10'd9; mem_in_m = 16'hBEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      cmp_n++; if (up_stall !== 1'b1 || mem_read_m !== 1'b1 || mem_write_m !== 1'b0
                   || mem_data_addr !== 10'd9) begin err_n++;
        $display("FAIL miss_wait%0d got %b%b%b/%h want 110/9",
                 c, up_stall, mem_read_m, mem_write_m, mem_data_addr); end
      tick();
    end
    mem_ready = 1;
    #1;
    cmp_n++; if (up_stall !== 1'b0 || up_in_m !== 16'hBEEF) begin err_n++;
      $display("FAIL miss_done got %b/%h want 0/beef", up_stall, up_in_m); end
    base = log_n;
    tick();
    up_read_m = 0;
    tick();
    tick();
    cmp_n++; if (log_n !== base + 2 || log_d[base] !== 16'h0001 || log_d[base+1] !== 16'h0002
                 || log_a[base+1] !== 10'd7 || buf_count !== 3'd0) begin err_n++;
      $display("FAIL miss_drain got n=%0d %h,%h cnt %0d want n=2 1,2 cnt 0",
               log_n - base, log_d[base], log_d[base+1], buf_count); end
  endtask

  task automatic test_wrap;
    int base;
    int pushed;
    int c;
    base = log_n; pushed = 0; c = 0;
    while (pushed < 10 && c < 200) begin
      up_write_m = 1; up_data_addr = 10'(32 + pushed); up_out_m = 16'(256 + pushed);
      mem_ready = c[0];
      #1;
      if (!up_stall) pushed++;
      cmp_n++; if (buf_count > 3'd4) begin err_n++;
        $display("FAIL wrap_count got %0d want <=4", buf_count); end
      tick();
      c++;
    end
    up_write_m = 0; mem_ready = 1;
    c = 0;
    while (buf_count != 3'd0 && c < 50) begin tick(); c++; end
    cmp_n++; if (pushed != 10 || buf_count !== 3'd0) begin err_n++;
      $display("FAIL wrap_timeout got pushed %0d cnt %0d want 10/0", pushed, buf_count); end
    cmp_n++; if (log_n - base != 10) begin err_n++;
      $display("FAIL wrap_lognum got %0d want 10", log_n - base); end
    for (int i = 0; i < 10 && base + i < 256; i++) begin
      cmp_n++; if (log_a[base+i] !== 10'(32 + i) || log_d[base+i] !== 16'(256 + i)) begin
        err_n++;
        $display("FAIL wrap_entry%0d got %h/%h want %h/%h", i,
                 log_a[base+i], log_d[base+i], 10'(32 + i), 16'(256 + i)); end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      up_write_m = 1; up_data_addr = 10'(48 + i); up_out_m = 16'(16'hC0 + i);
      tick();
    end
    up_write_m = 0;
    #1;
    cmp_n++; if (mem_write_m !== 1'b1 || buf_count !== 3'd3) begin err_n++;
      $display("FAIL rmid_pre got %b/%0d want 1/3", mem_write_m, buf_count); end
    base = log_n;
    resetN = 0;
    #1;
    cmp_n++; if (buf_count !== 3'd0 || mem_write_m !== 1'b0 || mem_data_addr !== 10'd0) begin
      err_n++;
      $display("FAIL rmid_async got %0d/%b/%h want 0/0/0", buf_count, mem_write_m, mem_data_addr); end
    tick();
    resetN = 1; mem_ready = 1;
    repeat (3) tick();
    cmp_n++; if (log_n !== base || buf_count !== 3'd0) begin err_n++;
      $display("FAIL rmid_discard got %0d writes cnt %0d want 0/0", log_n - base, buf_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_miss();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/ram_write_buffer.md
Name: ram_write_buffer

Overview:
- Posted-write buffer between the RAM cache's memory-side port and the physical data RAM.
- Absorbs CPU stores into a small FIFO and drains them to a RAM that can take a variable number of cycles per access (mem_ready handshake).
- Read misses from upstream are checked against buffered writes; on a match the youngest buffered data is forwarded, otherwise the read goes to RAM ahead of pending drains.

Parameters:
- DATA_WIDTH, 16, data word width.
- RAM_REGISTER_COUNT, 1024, RAM words; ADDR_BITS = $clog2(RAM_REGISTER_COUNT).
- DEPTH, 4, buffer entries; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- resetN  in  1  asynchronous, active-low reset.
- up_out_m  in  DATA_WIDTH  write data from cache.
- up_write_m  in  1  write request.
- up_read_m  in  1  read request (cache miss).
- up_data_addr  in  ADDR_BITS  access address.
- up_in_m  out  DATA_WIDTH  read data to cache.
- up_stall  out  1  upstream must hold its request stable.
- mem_in_m  in  DATA_WIDTH  RAM read data, valid when mem_ready=1 during a read.
- mem_out_m  out  DATA_WIDTH  RAM write data.
- mem_write_m  out  1  RAM write strobe.
- mem_read_m  out  1  RAM read strobe.
- mem_data_addr  out  ADDR_BITS  RAM address.
- mem_ready  in  1  RAM completes the presented access this cycle.
- buf_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH entries of {addr, data}. Read and write pointers are $clog2(DEPTH)+1 bits wide, with wrap-around. empty = pointers equal; full = indices equal and MSBs differ. buf_count = wr_ptr - rd_ptr.
- Reset (async): both pointers cleared, buffered contents discarded, buf_count=0. All outputs combinationally derived, so after reset: up_stall=0 with no request, and mem_write_m, mem_read_m, mem_out_m, mem_data_addr are all 0.
- Forward hit: up_read_m=1 and any valid entry has addr == up_data_addr.
  - Select the youngest matching entry (nearest to wr_ptr).
  - up_in_m = its data, combinationally; no stall.
- Read miss: up_read_m=1 and no match.
  - Drive mem_read_m=1 and mem_data_addr=up_data_addr.
  - up_in_m = mem_in_m.
  - up_stall = !mem_ready.
  - The drain is suppressed that cycle: reads have priority, because no address overlap is possible.
- Drain: when not empty and no read miss is active:
  - mem_write_m=1, mem_data_addr/mem_out_m = head entry.
  - On mem_ready=1, pop (rd_ptr+1).
  - The head stays presented until accepted.
- Idle memory port: mem_write_m=mem_read_m=0; address and data outputs = 0.
- Stall equation: up_stall = (up_write_m && full) || (up_read_m && !hit && !mem_ready).
- Push: when up_write_m && !up_stall. The entry is written at wr_ptr and wr_ptr advances at the clock edge. A full buffer stalls the write even if a pop occurs in the same cycle; this avoids a mem_ready-to-push combinational path.
- Simultaneous read and write:
  - The read is evaluated against the pre-write contents.
  - The push happens only in the first cycle up_stall=0.
  - No double push while stalled.
- Same-cycle push and pop: both pointers advance; count unchanged.
- Duplicate addresses in the buffer are allowed. They drain in FIFO order, so RAM ends with the youngest value.
- Throughput: one push per cycle while not full; one drain per mem_ready.

Decomposition:
- Shared package ram_pkg holds:
  - localparams ADDR_BITS (from RAM_REGISTER_COUNT) and the default DEPTH.
  - typedef wb_entry_t {logic [ADDR_BITS-1:0] addr; logic [DATA_WIDTH-1:0] data;}.
- One natural sub-module: wb_match. It is a combinational youngest-match priority search over the entries given rd_ptr/wr_ptr, and outputs hit plus the index of the youngest match.
- FIFO pointers and arbitration stay in the top level.

Test Plan:
- Reset with mem_ready=1: write 0x1234 to addr 5 → mem_write_m=1, addr 5, data 0x1234 on the next cycle; buf_count returns to 0.
- mem_ready=0: write addrs 1..4 (data 0xA1..0xA4) → no stall. Fifth write to addr 6 → up_stall=1. One mem_ready pulse → addr 1 drained, the addr 6 write pushes on the following cycle, buf_count=4.
- Buffer holds addr 7=0x0001 then addr 7=0x0002; read addr 7 → up_in_m=0x0002, up_stall=0, mem_read_m=0.
- Buffer non-empty, read addr 9 (miss) with mem_ready low 3 cycles → up_stall=1 for 3 cycles, mem_read_m=1 and mem_write_m=0 throughout. On mem_ready, up_in_m=mem_in_m=0xBEEF.
- Wrap-around: 10 writes with mem_ready toggling → RAM model receives all writes in order; pointers wrap; buf_count is never greater than 4.
- Assert resetN mid-drain with 3 entries → buf_count=0 and mem_write_m=0 immediately; discarded entries never reach RAM.
